uart_rx_byte: RTL and testbench



---
 rtl/uart_rx_byte_if.sv | 37 +++
 rtl/uart_rx_byte.sv | 144 ++++++++++++++
 tb/tb_uart_rx_byte.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_byte_if.sv
// ---------------------------------------------------------------------------
// uart_rx_byte_if
// Purpose : bundles the serial input and byte-output signals of the 8N1 UART
//           receiver so the receiver and its environment connect through one port.
// Signals :
//   rx        serial line, idles high, asynchronous to clk
//   rxdata    last correctly framed byte, LSB = first data bit received
//   rxfinish  one-cycle strobe, rxdata valid on the same cycle
//   frame_err one-cycle strobe when the stop bit samples low
//   busy      high whenever the receiver is not idle
// Modports:
//   master  drives rx and observes the receiver outputs
//   slave   the receiver itself
// ---------------------------------------------------------------------------
interface uart_rx_byte_if;
    logic       rx;
    logic [7:0] rxdata;
    logic       rxfinish;
    logic       frame_err;
    logic       busy;

    modport master (
        output rx,
        input  rxdata,
        input  rxfinish,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx,
        output rxdata,
        output rxfinish,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
// Purpose : 8N1 UART receiver feeding the cell/UART message buffer. Emits
//           exactly one rxfinish strobe per correctly framed byte and one
//           frame_err strobe per frame whose stop bit samples low.
// Ports   :
//   clk   system clock, all logic on posedge
//   rst   asynchronous, active-high reset
//   bus   uart_rx_byte_if.slave : rx in; rxdata, rxfinish, frame_err, busy out
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (>= 4)
//   CNT_WIDTH     derived width of the bit-period counter
// ---------------------------------------------------------------------------
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_byte_if.slave   bus
);

    localparam int CNT_WIDTH = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_WIDTH-1:0] HALF_CNT = CNT_WIDTH'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        RECOVER
    } state_t;

    state_t                 r_state;
    logic                   r_sync_p0;
    logic                   r_sync_p1;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shift;
    logic [7:0]             r_rxdata;
    logic                   r_rxfinish;
    logic                   r_frame_err;

    logic                   w_rx_s;

    // Synchronised line; every decision below looks only at this.
    assign w_rx_s = r_sync_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Synchroniser resets to the idle level so a line that is low at
            // release is seen as a fresh falling edge, never as a half frame.
            r_sync_p0   <= 1'b1;
            r_sync_p1   <= 1'b1;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_rxdata    <= '0;
            r_rxfinish  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            // --- stage p0 -> p1: two-flop synchroniser on rx ---
            r_sync_p0   <= bus.rx;
            r_sync_p1   <= r_sync_p0;

            // Strobes are single-cycle by default.
            r_rxfinish  <= 1'b0;
            r_frame_err <= 1'b0;

            // --- frame FSM on the synchronised line ---
            case (r_state)
                IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                    if (!w_rx_s) begin
                        r_state <= START;
                    end
                end

                START: begin
                    // Re-check the line at mid start bit to reject glitches.
                    if (r_cnt == HALF_CNT) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= w_rx_s ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end

                DATA: begin
                    // Sampling one full period after mid start keeps every
                    // data sample near the middle of its bit.
                    if (r_cnt == LAST_CNT) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end

                STOP: begin
                    if (r_cnt == LAST_CNT) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_rxdata   <= r_shift;
                            r_rxfinish <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= RECOVER;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end

                RECOVER: begin
                    // A held-low line (break) parks here: no byte, no repeat error.
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rxdata    = r_rxdata;
    assign bus.rxfinish  = r_rxfinish;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_byte
// Drives 8N1 frames into two receivers (8 and 434 clocks per bit). Each frame
// sent pushes its expected result into a queue; monitors pop and compare when
// the receiver strobes rxfinish or frame_err.
// ---------------------------------------------------------------------------
module tb_uart_rx_byte;

    localparam int CPB_A = 8;
    localparam int CPB_B = 434;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_byte_if ifa ();
    uart_rx_byte_if ifb ();

    uart_rx_byte #(.CLKS_PER_BIT(CPB_A)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    uart_rx_byte #(.CLKS_PER_BIT(CPB_B)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;

    exp_t       qa[$];
    exp_t       qb[$];
    logic [7:0] erra_q[$];
    int         fin_a[$];
    logic [7:0] good_a = 8'h00;
    logic [7:0] good_b = 8'h00;

    task automatic chk(input string name, input bit ok, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        chk(name, act == exp, act, exp);
    endtask

    // Rising-edge-to-rxfinish delay in clk cycles: two synchroniser flops and
    // one cycle for IDLE to react, half a bit to the mid start-bit check,
    // nine whole bits on to the mid stop-bit sample, one cycle to register.
    function automatic int lat(input int cpb);
        return 3 + ((cpb - 1) / 2 + 1) + 9 * cpb;
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0) begin
            if (ifa.rxfinish && ifa.frame_err) check("a_strobe_exclusive", 1, 0);
            if (ifa.rxfinish) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_rxfinish", 1'b0, ifa.rxdata, 0);
                end else begin
                    e = qa.pop_front();
                    check("a_rxdata", ifa.rxdata, e.data);
                    chk("a_latency", (cyc - e.start >= lat(CPB_A) - 1) && (cyc - e.start <= lat(CPB_A) + 1),
                        cyc - e.start, lat(CPB_A));
                    fin_a.push_back(cyc);
                end
            end
            if (ifa.frame_err) begin
                if (erra_q.size() == 0) chk("a_unexpected_frame_err", 1'b0, 1, 0);
                else check("a_ferr_rxdata_hold", ifa.rxdata, erra_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0) begin
            if (ifb.frame_err) chk("b_unexpected_frame_err", 1'b0, 1, 0);
            if (ifb.rxfinish) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_rxfinish", 1'b0, ifb.rxdata, 0);
                end else begin
                    e = qb.pop_front();
                    check("b_rxdata", ifb.rxdata, e.data);
                    chk("b_latency", (cyc - e.start >= lat(CPB_B) - 4) && (cyc - e.start <= lat(CPB_B) + 4),
                        cyc - e.start, lat(CPB_B));
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic set_rx(input int which, input logic v);
        if (which == 0) ifa.rx = v;
        else            ifb.rx = v;
    endtask

    task automatic hold(input int which, input logic v, input int n);
        set_rx(which, v);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int which, input logic [7:0] d, input logic stop);
        int   cpb;
        exp_t e;
        cpb    = (which == 0) ? CPB_A : CPB_B;
        e.data = d;
        e.start = cyc;
        if (which == 0) begin
            if (stop) begin qa.push_back(e); good_a = d; end
            else      erra_q.push_back(good_a);
        end else begin
            if (stop) begin qb.push_back(e); good_b = d; end
        end
        hold(which, 1'b0, cpb);
        for (int i = 0; i < 8; i++) hold(which, d[i], cpb);
        hold(which, stop, cpb);
    endtask

    task automatic wait_idle(input int which, input int bound);
        int n;
        n = 0;
        if (which == 0) begin
            while ((qa.size() != 0 || erra_q.size() != 0 || ifa.busy) && n < bound) begin
                @(posedge clk); #1; n++;
            end
        end else begin
            while ((qb.size() != 0 || ifb.busy) && n < bound) begin
                @(posedge clk); #1; n++;
            end
        end
        chk("idle_timeout", n < bound, n, bound);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] d;
        logic       stop;
        logic       saw_busy;
        logic       busy_k[10];
        int         gap;

        ifa.rx = 1'b1;
        ifb.rx = 1'b1;
        rst    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_rxdata", ifa.rxdata, 0);
        check("rst_a_rxfinish", ifa.rxfinish, 0);
        check("rst_a_frame_err", ifa.frame_err, 0);
        check("rst_a_busy", ifa.busy, 0);
        check("rst_b_rxdata", ifb.rxdata, 0);
        check("rst_b_busy", ifb.busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        hold(0, 1'b1, 4);

        // single frame 0xA5
        send(0, 8'hA5, 1'b1);
        hold(0, 1'b1, 2 * CPB_A);
        wait_idle(0, 200);
        check("t1_busy_after", ifa.busy, 0);

        // three back-to-back frames
        fin_a.delete();
        send(0, 8'h03, 1'b1);
        send(0, 8'h07, 1'b1);
        send(0, 8'h01, 1'b1);
        hold(0, 1'b1, 2 * CPB_A);
        wait_idle(0, 200);
        check("t2_pulse_count", fin_a.size(), 3);
        if (fin_a.size() == 3) begin
            check("t2_spacing_1", fin_a[1] - fin_a[0], 10 * CPB_A);
            check("t2_spacing_2", fin_a[2] - fin_a[1], 10 * CPB_A);
        end

        // two-cycle glitch: brief busy, no strobe
        hold(0, 1'b0, 2);
        set_rx(0, 1'b1);
        saw_busy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            busy_k[k] = ifa.busy;
            if (ifa.busy) saw_busy = 1'b1;
        end
        @(posedge clk); #1;
        check("t3_busy_seen", saw_busy, 1);
        check("t3_idle_by_6", busy_k[6], 0);
        check("t3_idle_end", busy_k[9], 0);
        hold(0, 1'b1, CPB_A);

        // bad stop bit, break, then a good frame
        send(0, 8'h5A, 1'b0);
        hold(0, 1'b0, 40);
        check("t4_busy_in_break", ifa.busy, 1);
        check("t4_rxdata_held", ifa.rxdata, 8'h01);
        hold(0, 1'b1, 3 * CPB_A);
        send(0, 8'h3C, 1'b1);
        hold(0, 1'b1, 2 * CPB_A);
        wait_idle(0, 200);

        // randomized frames, occasional bad stop bit
        repeat (24) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            send(0, d, stop);
            gap = stop ? int'($urandom_range(0, 12)) : CPB_A + int'($urandom_range(0, 12));
            if (gap > 0) hold(0, 1'b1, gap);
        end
        hold(0, 1'b1, 2 * CPB_A);
        wait_idle(0, 400);

        // reset during bit 4 of a 0xFF frame, then 0x81
        hold(0, 1'b0, CPB_A);
        for (int i = 0; i < 4; i++) hold(0, 1'b1, CPB_A);
        hold(0, 1'b1, 3);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_rxdata", ifa.rxdata, 0);
        check("t5_rst_rxfinish", ifa.rxfinish, 0);
        check("t5_rst_frame_err", ifa.frame_err, 0);
        check("t5_rst_busy", ifa.busy, 0);
        @(posedge clk); #1;
        rst    = 1'b0;
        good_a = 8'h00;
        good_b = 8'h00;
        hold(0, 1'b1, 3 * CPB_A);
        send(0, 8'h81, 1'b1);
        hold(0, 1'b1, 2 * CPB_A);
        wait_idle(0, 200);

        // long bit period, frame 0x00
        hold(1, 1'b1, 4);
        send(1, 8'h00, 1'b1);
        hold(1, 1'b1, CPB_B);
        wait_idle(1, 6000);

        check("end_qa_empty", qa.size(), 0);
        check("end_erra_empty", erra_q.size(), 0);
        check("end_qb_empty", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
